// File: rtl/decode_issue_stage_pkg.sv
// ============================================================================
// Module : decode_issue_stage_pkg
// Brief  : Instruction field positions, opcode classes and decode helpers
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package decode_issue_stage_pkg;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;
   localparam int R0_IDX = 0;

   localparam logic [5:0] OP_RTYPE = 6'b000000;

   typedef enum logic [1:0] {
      OPC_RTYPE = 2'd0,
      OPC_ITYPE = 2'd1,
      OPC_STBR  = 2'd2,
      OPC_OTHER = 2'd3
   } opclass_e;

   function automatic opclass_e op_class(input logic [5:0] op);
      if (op == OP_RTYPE)
         return OPC_RTYPE;
      else if (op[5])
         return OPC_ITYPE;
      else if (op[5:4] == 2'b01)
         return OPC_STBR;
      else
         return OPC_OTHER;
   endfunction

   function automatic logic op_writes(input opclass_e cls);
      return (cls == OPC_RTYPE) || (cls == OPC_ITYPE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/decode_issue_stage_reg_scoreboard.sv
// ============================================================================
// Module : decode_issue_stage_reg_scoreboard
// Brief  : Busy vector of in-flight register writes with set/clear/flush
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_issue_stage_reg_scoreboard
   import decode_issue_stage_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_flush,
   input  logic                  i_set,
   input  logic [AW-1:0]         i_set_idx,
   input  logic                  i_clr,
   input  logic [AW-1:0]         i_clr_idx,
   output logic [(1<<AW)-1:0]    o_eff_busy
);

   logic [(1<<AW)-1:0] r_busy;
   logic [(1<<AW)-1:0] w_set_mask;
   logic [(1<<AW)-1:0] w_clr_mask;

   // r0 is never tracked, so a writer to r0 cannot cause a stall
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_set && (i_set_idx != AW'(R0_IDX)))
         w_set_mask[i_set_idx] = 1'b1;
      if (i_clr)
         w_clr_mask[i_clr_idx] = 1'b1;
   end

   assign o_eff_busy = r_busy & ~w_clr_mask;

   // Set is OR-ed after the clear so a same-cycle set on the cleared reg wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_busy <= '0;
      else if (i_flush)
         r_busy <= '0;
      else
         r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
   end

endmodule

`default_nettype wire

// File: rtl/decode_issue_stage.sv
// ============================================================================
// Module : decode_issue_stage
// Brief  : Decode/issue with writeback bypass, hazard stall and output stage
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_issue_stage
   import decode_issue_stage_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          In_Valid,
   output logic          In_Ready,
   input  logic [31:0]   In_Instr,
   output logic [AW-1:0] RF_Adr1,
   output logic [AW-1:0] RF_Adr2,
   input  logic [DW-1:0] RF_Dout1,
   input  logic [DW-1:0] RF_Dout2,
   input  logic          WB_Valid,
   input  logic [AW-1:0] WB_Awr,
   input  logic [DW-1:0] WB_Din,
   input  logic          Flush,
   output logic          Out_Valid,
   input  logic          Out_Ready,
   output logic [5:0]    Out_Op,
   output logic [DW-1:0] Out_A,
   output logic [DW-1:0] Out_B,
   output logic [DW-1:0] Out_Imm,
   output logic [AW-1:0] Out_Dst,
   output logic          Out_WrReg
);

   logic [5:0]         w_op;
   logic [AW-1:0]      w_rs, w_rt, w_rd, w_dst;
   logic [15:0]        w_imm;
   opclass_e           w_cls;
   logic               w_wr, w_hazard, w_issue;
   logic [DW-1:0]      w_opa, w_opb;
   logic [(1<<AW)-1:0] w_eff_busy;

   logic               r_out_valid;
   logic [5:0]         r_op;
   logic [DW-1:0]      r_a, r_b, r_imm;
   logic [AW-1:0]      r_dst;
   logic               r_wr;

   assign w_op  = In_Instr[OP_HI:OP_LO];
   assign w_rs  = In_Instr[RS_HI:RS_LO];
   assign w_rt  = In_Instr[RT_HI:RT_LO];
   assign w_rd  = In_Instr[RD_HI:RD_LO];
   assign w_imm = In_Instr[IMM_HI:IMM_LO];

   assign w_cls = op_class(w_op);
   assign w_dst = (w_cls == OPC_RTYPE) ? w_rd : w_rt;
   assign w_wr  = op_writes(w_cls) && (w_dst != AW'(R0_IDX));

   assign RF_Adr1 = w_rs;
   assign RF_Adr2 = w_rt;

   // Writeback landing this edge is visible to the instruction being issued
   always_comb begin
      w_opa = RF_Dout1;
      w_opb = RF_Dout2;
      if (w_rs == AW'(R0_IDX))
         w_opa = '0;
      else if (WB_Valid && (WB_Awr == w_rs))
         w_opa = WB_Din;
      if (w_rt == AW'(R0_IDX))
         w_opb = '0;
      else if (WB_Valid && (WB_Awr == w_rt))
         w_opb = WB_Din;
   end

   assign w_hazard = w_eff_busy[w_rs] | w_eff_busy[w_rt] | (w_wr & w_eff_busy[w_dst]);
   assign In_Ready = ~Flush & ~(In_Valid & w_hazard) & (~r_out_valid | Out_Ready);
   assign w_issue  = In_Valid & In_Ready;

   decode_issue_stage_reg_scoreboard #(
      .AW (AW)
   ) u_sb (
      .clk        (Clk),
      .rst_n      (Rst_n),
      .i_flush    (Flush),
      .i_set      (w_issue & w_wr),
      .i_set_idx  (w_dst),
      .i_clr      (WB_Valid),
      .i_clr_idx  (WB_Awr),
      .o_eff_busy (w_eff_busy)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_out_valid <= 1'b0;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_imm       <= '0;
         r_dst       <= '0;
         r_wr        <= 1'b0;
      end else if (Flush) begin
         r_out_valid <= 1'b0;
      end else if (w_issue) begin
         r_out_valid <= 1'b1;
         r_op        <= w_op;
         r_a         <= w_opa;
         r_b         <= w_opb;
         r_imm       <= {{(DW-16){w_imm[15]}}, w_imm};
         r_dst       <= w_dst;
         r_wr        <= w_wr;
      end else if (Out_Ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign Out_Valid = r_out_valid;
   assign Out_Op    = r_op;
   assign Out_A     = r_a;
   assign Out_B     = r_b;
   assign Out_Imm   = r_imm;
   assign Out_Dst   = r_dst;
   assign Out_WrReg = r_wr;

endmodule

`default_nettype wire
